// File: rtl/pc_fetch_if.sv
// Fetch-unit bundle: PC/adder loop, redirect, imem req/gnt/rvalid and decode valid/ready.
// Latency: none, wires only.
// Backpressure: imem via gnt, decode via instr_ready.
interface pc_fetch_if;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [31:0] fetch_count;

    modport master (
        output pc, imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_count,
        input  pc_plus4, redirect_valid, redirect_pc, imem_gnt, imem_rvalid,
               imem_rdata, instr_ready
    );

    modport slave (
        input  pc, imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_count,
        output pc_plus4, redirect_valid, redirect_pc, imem_gnt, imem_rvalid,
               imem_rdata, instr_ready
    );
endinterface

// File: rtl/pc_fetch.sv
// PC register and single-outstanding instruction fetch with redirect/kill.
// Latency: grant-to-rvalid delay + 1 cycle to instr_valid; best case one instr per 3 cycles.
// Backpressure: imem_req held until gnt; instr held in HOLD until instr_ready or redirect.
module pc_fetch #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter logic [31:0] FETCH_COUNT_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t      state;
    logic        kill;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        instr_valid_q;
    logic [31:0] fetch_count_q;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            kill          <= 1'b0;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= FETCH_COUNT_INIT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.redirect_valid)
                        pc_q <= redirect_tgt;
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (bus.redirect_valid)
                        pc_q <= redirect_tgt;
                    if (bus.imem_gnt) begin
                        // A grant coinciding with a redirect fetched the old address.
                        kill  <= bus.redirect_valid;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.redirect_valid) begin
                        pc_q <= redirect_tgt;
                        if (bus.imem_rvalid) begin
                            kill  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            kill  <= 1'b1;
                        end
                    end else if (bus.imem_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            instr_q       <= bus.imem_rdata;
                            instr_pc_q    <= pc_q;
                            pc_q          <= bus.pc_plus4;
                            instr_valid_q <= 1'b1;
                            state         <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.redirect_valid || bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state         <= ST_REQ;
                        if (bus.instr_ready)
                            fetch_count_q <= fetch_count_q + 32'd1;
                        if (bus.redirect_valid)
                            pc_q <= redirect_tgt;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.imem_req    = (state == ST_REQ);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: boot, stall, redirects, wrap and async reset.
// Latency: inputs driven 1 time unit after posedge, outputs checked at the same point.
// Backpressure: decode ready and imem grant driven directly by the vectors.
module tb_pc_fetch;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    pc_fetch_if bus ();
    pc_fetch_if wbus ();

    pc_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Second instance preset one below wrap; mirrors all stimulus of the main one.
    pc_fetch #(.RESET_PC(32'h0000_0100), .FETCH_COUNT_INIT(32'hFFFF_FFFF)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbus)
    );

    assign bus.pc_plus4        = bus.pc + 32'd4;
    assign wbus.pc_plus4       = wbus.pc + 32'd4;
    assign wbus.redirect_valid = bus.redirect_valid;
    assign wbus.redirect_pc    = bus.redirect_pc;
    assign wbus.imem_gnt       = bus.imem_gnt;
    assign wbus.imem_rvalid    = bus.imem_rvalid;
    assign wbus.imem_rdata     = bus.imem_rdata;
    assign wbus.instr_ready    = bus.instr_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.instr_ready    = 1'b0;

        // Reset state
        tick();
        chk("rst_pc", bus.pc, 32'h100);
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_vld", {31'h0, bus.instr_valid}, 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_cnt", bus.fetch_count, 32'h0);
        chk("rst_cnt_preset", wbus.fetch_count, 32'hFFFF_FFFF);

        // Boot fetch at RESET_PC
        rst_n = 1'b1;
        tick();
        chk("boot_req", {31'h0, bus.imem_req}, 32'h1);
        chk("boot_addr", bus.imem_addr, 32'h100);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        chk("wait_req", {31'h0, bus.imem_req}, 32'h0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("boot_vld", {31'h0, bus.instr_valid}, 32'h1);
        chk("boot_instr", bus.instr, 32'hDEAD_BEEF);
        chk("boot_instr_pc", bus.instr_pc, 32'h100);
        chk("boot_pc", bus.pc, 32'h104);

        // Stall in HOLD
        for (int i = 0; i < 10; i++) tick();
        chk("stall_instr", bus.instr, 32'hDEAD_BEEF);
        chk("stall_instr_pc", bus.instr_pc, 32'h100);
        chk("stall_req", {31'h0, bus.imem_req}, 32'h0);
        chk("stall_vld", {31'h0, bus.instr_valid}, 32'h1);
        chk("stall_cnt", bus.fetch_count, 32'h0);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        chk("accept_cnt", bus.fetch_count, 32'h1);
        chk("accept_cnt_wrap", wbus.fetch_count, 32'h0);
        chk("accept_vld", {31'h0, bus.instr_valid}, 32'h0);
        chk("next_req", {31'h0, bus.imem_req}, 32'h1);
        chk("next_addr", bus.imem_addr, 32'h104);

        // Redirect while waiting: response discarded, low bits forced to zero
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h203;
        tick();
        bus.redirect_valid = 1'b0;
        chk("rw_pc", bus.pc, 32'h200);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0BAD_0001;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("rw_vld", {31'h0, bus.instr_valid}, 32'h0);
        chk("rw_req", {31'h0, bus.imem_req}, 32'h1);
        chk("rw_addr", bus.imem_addr, 32'h200);

        // Redirect together with grant
        bus.imem_gnt       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        tick();
        bus.imem_gnt       = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("rg_req", {31'h0, bus.imem_req}, 32'h0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0BAD_0002;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("rg_vld", {31'h0, bus.instr_valid}, 32'h0);
        chk("rg_addr", bus.imem_addr, 32'h300);
        chk("rg_req2", {31'h0, bus.imem_req}, 32'h1);

        // Redirect together with rvalid
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b1;
        bus.imem_rdata     = 32'h0BAD_0003;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h404;
        tick();
        bus.imem_rvalid    = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("rr_vld", {31'h0, bus.instr_valid}, 32'h0);
        chk("rr_req", {31'h0, bus.imem_req}, 32'h1);
        chk("rr_addr", bus.imem_addr, 32'h404);

        // Clean fetch at the target, then redirect together with ready
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h3333_3333;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("tgt_instr", bus.instr, 32'h3333_3333);
        chk("tgt_instr_pc", bus.instr_pc, 32'h404);
        chk("tgt_pc", bus.pc, 32'h408);
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("rh_cnt", bus.fetch_count, 32'h2);
        chk("rh_vld", {31'h0, bus.instr_valid}, 32'h0);
        chk("rh_addr", bus.imem_addr, 32'hFFFF_FFFC);

        // PC wrap
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h4444_4444;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pc", bus.pc, 32'h0);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_cnt", bus.fetch_count, 32'h3);
        chk("wrap_cnt_preset", wbus.fetch_count, 32'h2);

        // Async reset mid-WAIT, then a late response
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_pc", bus.pc, 32'h100);
        chk("ar_req", {31'h0, bus.imem_req}, 32'h0);
        chk("ar_vld", {31'h0, bus.instr_valid}, 32'h0);
        chk("ar_instr", bus.instr, 32'h0);
        chk("ar_instr_pc", bus.instr_pc, 32'h0);
        chk("ar_cnt", bus.fetch_count, 32'h0);
        tick();
        rst_n           = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0BAD_0004;
        tick();
        chk("late_req", {31'h0, bus.imem_req}, 32'h1);
        chk("late_addr", bus.imem_addr, 32'h100);
        tick();
        bus.imem_rvalid = 1'b0;
        chk("late_vld", {31'h0, bus.instr_valid}, 32'h0);
        chk("late_req2", {31'h0, bus.imem_req}, 32'h1);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h5555_5555;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("reboot_instr", bus.instr, 32'h5555_5555);
        chk("reboot_instr_pc", bus.instr_pc, 32'h100);
        chk("reboot_pc", bus.pc, 32'h104);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
